// File: rtl/dbus_timer.sv
// dbus_timer: memory-mapped timer/compare peripheral on the CPU data bus.
// Register window of four words: CTRL, PRESCALE, COUNT, COMPARE.
// Provides a prescaled counter (free-running with reload, or one-shot),
// a sticky compare MATCH flag (write-1-to-clear) and a level interrupt.
module dbus_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0800,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic        hit,
  output logic        irq
);

  localparam logic [PRESCALE_W-1:0] PCNT_ONE = PRESCALE_W'(1);

  logic                  en, reload, irq_en, match;
  logic [PRESCALE_W-1:0] prescale, pcnt;
  logic [31:0]           count, compare;

  logic [31:0] lane_mask, prescale_ext, prescale_new, count_new, compare_new;
  logic        wr, wr_ctrl, wr_pre, wr_count, wr_cmp;
  logic        tick, step, set_match;
  logic        unused_bits;

  assign hit       = (daddr[31:4] == BASE_ADDR[31:4]);
  assign lane_mask = {{8{dwe[3]}}, {8{dwe[2]}}, {8{dwe[1]}}, {8{dwe[0]}}};

  assign wr       = hit & (|dwe);
  assign wr_ctrl  = wr & (daddr[3:2] == 2'd0);
  assign wr_pre   = wr & (daddr[3:2] == 2'd1);
  assign wr_count = wr & (daddr[3:2] == 2'd2);
  assign wr_cmp   = wr & (daddr[3:2] == 2'd3);

  // A CPU write to COUNT overrides the tick entirely (no increment, no compare).
  assign tick      = en & (pcnt == prescale);
  assign step      = tick & ~wr_count;
  assign set_match = step & (count == compare);

  // Zero-extend the prescaler so byte-lane merging works on a full word.
  always_comb begin
    prescale_ext = '0;
    prescale_ext[PRESCALE_W-1:0] = prescale;
  end

  assign prescale_new = (prescale_ext & ~lane_mask) | (dwdata & lane_mask);
  assign count_new    = (count        & ~lane_mask) | (dwdata & lane_mask);
  assign compare_new  = (compare      & ~lane_mask) | (dwdata & lane_mask);

  // Byte address bits and the upper prescale bits are intentionally ignored.
  assign unused_bits = &{1'b0, daddr[1:0], prescale_new};

  assign irq = match & irq_en;

  // Zero-latency register read mux; reads 0 outside the window.
  always_comb begin
    drdata = 32'h0;
    if (hit) begin
      case (daddr[3:2])
        2'd0:    drdata = {23'h0, match, 5'h0, irq_en, reload, en};
        2'd1:    drdata = prescale_ext;
        2'd2:    drdata = count;
        default: drdata = compare;
      endcase
    end
  end

  // Prescaler: counts while enabled, restarts on tick or on CTRL/PRESCALE writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 pcnt <= '0;
    else if (wr_ctrl | wr_pre) pcnt <= '0;
    else if (!en || tick)      pcnt <= '0;
    else                       pcnt <= pcnt + PCNT_ONE;
  end

  // CTRL bits: one-shot auto-disable loses to a CPU EN write; match set beats W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en     <= 1'b0;
      reload <= 1'b0;
      irq_en <= 1'b0;
      match  <= 1'b0;
    end else begin
      if (set_match) begin
        match <= 1'b1;
        if (!reload) en <= 1'b0;
      end
      if (wr_ctrl && dwe[0]) begin
        en     <= dwdata[0];
        reload <= dwdata[1];
        irq_en <= dwdata[2];
      end
      if (wr_ctrl && dwe[1] && dwdata[8] && !set_match) match <= 1'b0;
    end
  end

  // COUNT: CPU write wins, else advance on tick (reload to 0 or hold on match).
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          count <= 32'h0;
    else if (wr_count)  count <= count_new;
    else if (set_match) count <= reload ? 32'h0 : count;
    else if (step)      count <= count + 32'd1;
  end

  // PRESCALE and COMPARE are plain byte-writable registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale <= '0;
      compare  <= 32'h0;
    end else begin
      if (wr_pre) prescale <= prescale_new[PRESCALE_W-1:0];
      if (wr_cmp) compare  <= compare_new;
    end
  end

endmodule

// File: doc/dbus_timer.md
Name: dbus_timer

Overview:
- Memory-mapped timer/compare peripheral on the CPU data bus, in parallel with dmem, using the same daddr/dwdata/dwe/drdata signalling.
- Top-level glue muxes drdata from this block when hit=1 and from dmem otherwise.
- Provides a free-running or one-shot counter with a programmable prescaler, a compare match flag and a level interrupt. Test programs use it for timed polling.

Parameters:
BASE_ADDR, 32'h0000_0800, byte address of register window (16 bytes, 16-byte aligned)
PRESCALE_W, 16, width of prescaler register/counter (1..32)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
daddr  input  32  data bus byte address from CPU
dwdata  input  32  write data from CPU
dwe  input  4  byte write enables, bit n = byte lane n (dwdata[8n+7:8n])
drdata  output  32  read data, combinational
hit  output  1  combinational, 1 when daddr[31:4] == BASE_ADDR[31:4]
irq  output  1  interrupt, level, = MATCH & IRQ_EN

Behaviour:
- Register map, selected by daddr[3:2] when hit; daddr[1:0] is ignored:
  - 0x0 CTRL: bit0 EN, bit1 RELOAD, bit2 IRQ_EN, bit8 MATCH (read / write-1-to-clear); other bits read 0.
  - 0x4 PRESCALE[PRESCALE_W-1:0]; upper bits read 0.
  - 0x8 COUNT[31:0].
  - 0xC COMPARE[31:0].
- Reset (async, immediate): all registers = 0, prescaler counter pcnt = 0. Consequently irq=0. drdata follows daddr combinationally.
- Reads: drdata = selected register when hit, else 32'h0. Reads have zero latency and no side effects.
- Writes: occur on the clk edge when hit and dwe!=0. Only enabled byte lanes update. A byte lane covering CTRL bit8 clears MATCH if dwdata[8]=1.
- Prescaler:
  - When EN=1: pcnt increments each cycle.
  - When pcnt == PRESCALE: tick=1 and pcnt <= 0. PRESCALE=0 therefore ticks every cycle.
  - When EN=0: pcnt held at 0, no ticks.
  - Any write to PRESCALE or CTRL clears pcnt.
- On tick:
  - If COUNT == COMPARE: MATCH <= 1. Then, if RELOAD=1, COUNT <= 0; else EN <= 0 and COUNT holds (one-shot).
  - Else COUNT <= COUNT + 1, wrapping 32'hFFFF_FFFF -> 0 with no flag.
- Simultaneous events:
  - CPU write to COUNT in the same cycle as a tick: the CPU value wins; the increment and compare are skipped that cycle.
  - W1C of MATCH in the same cycle as a match: the set wins (MATCH stays 1).
  - CPU write to CTRL.EN in the same cycle as a one-shot auto-clear: the CPU value wins.
- Timing: irq is purely from flops, so it asserts the cycle after the match edge.
- Reset mid-count: everything returns to 0 immediately; the timer remains disabled until software re-enables it.
- Unused addresses (daddr[3:2] beyond map): not applicable, since all four words are defined.
- When hit=0, writes are ignored and state is unaffected.

Test Plan:
- Reset: assert reset for 100 ns -> all four regs read 0, irq=0, hit=1 only for daddr 0x800..0x80F.
- Basic count:
  - Setup: PRESCALE=0, COMPARE=5, CTRL=0x1.
  - Response: COUNT reads 1,2,3,4,5 on successive cycles.
  - On the next tick MATCH=1 and EN auto-clears; COUNT stays 5; irq stays 0 since IRQ_EN=0.
- Prescale + reload + irq:
  - Setup: PRESCALE=3, COMPARE=2, CTRL=0x7.
  - Response: COUNT increments every 4 cycles (0,1,2,0,...).
  - MATCH and irq assert after the 3rd tick.
  - Writing CTRL=0x107 clears MATCH/irq; it reasserts 12 cycles later.
- Byte lanes: write 32'hAABBCCDD to COMPARE with dwe=4'b0101 (COMPARE previously 0) -> COMPARE reads 32'h00BB00DD; dmem-side addresses are unaffected.
- Collisions:
  - Write COUNT=100 in a tick cycle -> reads 100 the next cycle, not 101.
  - W1C MATCH in the match cycle -> MATCH stays 1.
- Wrap and reset: COUNT=32'hFFFF_FFFF, COMPARE=7, EN=1, PRESCALE=0 -> next COUNT=0, MATCH=0. Assert reset mid-run -> all regs 0 asynchronously, before the next clk edge.
